// File: rtl/aes_enc_round_if.sv
// rtl/aes_enc_round_if.sv - start/result and key-expansion control bundle for aes_enc_round
interface aes_enc_round_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] rk;
  logic         ke_sel;
  logic         ke_rd;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  modport master (
    output start, plaintext, rk,
    input  ke_sel, ke_rd, busy, done, ciphertext
  );

  modport slave (
    input  start, plaintext, rk,
    output ke_sel, ke_rd, busy, done, ciphertext
  );
endinterface

// File: rtl/aes_enc_round.sv
// rtl/aes_enc_round.sv - iterative AES-128 encryption, one round per clock
// Round keys are pulled from the upstream key expansion stage via ke_sel/ke_rd.

module aes_sbox (
  input  logic [7:0] B,
  output logic [7:0] D
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254 = b^2 * b^4 * ... * b^128; 0 maps to 0.
  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign D = sbox_calc(B);
endmodule

module aes_enc_round #(
  parameter int ROUNDS = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  aes_enc_round_if.slave bus
);
  if (ROUNDS != 10) begin : g_bad_rounds
    $error("aes_enc_round: only ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [3:0] LP_LAST = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDKEY,
    S_ROUND,
    S_FINAL
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_next;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_ct;
  logic         r_busy;
  logic         r_done;
  logic         w_ke_sel;
  logic         w_ke_rd;
  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;
  logic [127:0] w_round_out;
  logic [127:0] w_final_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k of the block sits at [127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .B (r_state[127-8*g -: 8]),
      .D (w_sub[127-8*g -: 8])
    );
  end

  assign w_shift     = shift_rows(w_sub);
  assign w_mix       = mix_columns(w_shift);
  assign w_round_out = w_mix ^ bus.rk;
  assign w_final_out = w_shift ^ bus.rk;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_ke_sel   = 1'b0;
    w_ke_rd    = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (bus.start) w_fsm_next = S_LOAD;
      end
      S_LOAD: begin
        w_ke_sel   = 1'b1;
        w_fsm_next = S_ADDKEY;
      end
      S_ADDKEY: begin
        w_ke_rd    = 1'b1;
        w_fsm_next = S_ROUND;
      end
      S_ROUND: begin
        w_ke_rd = 1'b1;
        if (r_round == LP_LAST) w_fsm_next = S_FINAL;
      end
      S_FINAL: begin
        w_fsm_next = S_IDLE;
      end
      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase
  end

  // r_state doubles as the plaintext capture register until ADDKEY.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= '0;
      r_ct    <= '0;
      r_round <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= bus.plaintext;
            r_busy  <= 1'b1;
          end
        end
        S_ADDKEY: begin
          r_state <= r_state ^ bus.rk;
          r_round <= 4'd1;
        end
        S_ROUND: begin
          r_state <= w_round_out;
          r_round <= r_round + 4'd1;
        end
        S_FINAL: begin
          r_ct    <= w_final_out;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_round <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ke_sel     = w_ke_sel;
  assign bus.ke_rd      = w_ke_rd;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ciphertext = r_ct;
endmodule

// File: tb/tb_aes_enc_round.sv
// tb/tb_aes_enc_round.sv - randomized self-checking bench for aes_enc_round
module tb_aes_enc_round;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  aes_enc_round_if bus ();

  aes_enc_round #(.ROUNDS(10)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] sbox_t [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [127:0] o;
    k = round_key(key, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      k = round_key(key, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream key expansion stage: no reset, loads on sel, advances on rd up to round 10.
  logic [127:0] tb_key = '0;
  logic [127:0] up_key = '0;
  int           up_idx = 0;
  always @(posedge CLK) begin
    if (bus.ke_sel) begin
      up_key <= tb_key;
      up_idx <= 0;
    end else if (bus.ke_rd && up_idx < 10) begin
      up_idx <= up_idx + 1;
    end
  end
  assign bus.rk = round_key(up_key, up_idx);

  // Model: m_t counts edges since the accepted start (-1 when idle).
  int           m_t = -1;
  logic [127:0] m_ct = '0;
  logic [127:0] m_pend = '0;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_t  = -1;
      m_ct = '0;
    end else if ((m_t < 0 || m_t == 12) && bus.start === 1'b1) begin
      m_t    = 0;
      m_pend = aes_ref(tb_key, bus.plaintext);
    end else if (m_t >= 0 && m_t < 12) begin
      m_t++;
      if (m_t == 12) m_ct = m_pend;
    end else begin
      m_t = -1;
    end
  end

  int n_sel = 0;
  int n_rd = 0;
  always @(negedge CLK) begin
    if (!RST_N) begin
      n_sel = 0;
      n_rd  = 0;
    end else begin
      chk("busy",       128'(bus.busy),   128'(m_t >= 0 && m_t < 12));
      chk("done",       128'(bus.done),   128'(m_t == 12));
      chk("ke_sel",     128'(bus.ke_sel), 128'(m_t == 0));
      chk("ke_rd",      128'(bus.ke_rd),  128'(m_t >= 1 && m_t <= 10));
      chk("ciphertext", bus.ciphertext,   m_ct);
      if (bus.ke_sel === 1'b1) n_sel++;
      if (bus.ke_rd === 1'b1) n_rd++;
      if (m_t == 12) begin
        chk("sel_pulses", 128'(n_sel), 128'd1);
        chk("rd_cycles",  128'(n_rd),  128'd10);
        n_sel = 0;
        n_rd  = 0;
      end
    end
  end

  task automatic wait_done(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_seen", 128'(ok), 128'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},   128'(bus.busy),   128'd0);
    chk({tag, "_done"},   128'(bus.done),   128'd0);
    chk({tag, "_ke_sel"}, 128'(bus.ke_sel), 128'd0);
    chk({tag, "_ke_rd"},  128'(bus.ke_rd),  128'd0);
    chk({tag, "_ct"},     bus.ciphertext,   128'd0);
    chk({tag, "_state"},  dut.r_state,      128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    logic [127:0] p;
    bus.start     = 1'b0;
    bus.plaintext = '0;
    #1 RST_N = 1'b0;
    #2 check_zero_outputs("reset");
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;

    chk("model_appB",  aes_ref(KEY_B, PT_B), CT_B);
    chk("model_appC1", aes_ref(KEY_C, PT_C), CT_C);
    chk("model_rk1",   round_key(KEY_B, 1), 128'ha0fafe1788542cb123a339392a6c7605);

    // FIPS-197 App. B with internal probes
    @(negedge CLK);
    tb_key = KEY_B; bus.plaintext = PT_B; bus.start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("probe_e2_state", dut.r_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("probe_round1_rk", bus.rk, 128'ha0fafe1788542cb123a339392a6c7605);
    @(posedge CLK);
    #1 chk("probe_e3_state", dut.r_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    repeat (9) @(posedge CLK);
    #1;
    chk("appB_done_at_12", 128'(bus.done), 128'd1);
    chk("appB_ct", bus.ciphertext, CT_B);

    // App. C.1 started in the done cycle, start held then toggled during the run
    @(negedge CLK);
    tb_key = KEY_C; bus.plaintext = PT_C; bus.start = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      bus.start     = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      @(posedge CLK);
    end
    #1;
    chk("appC1_done_at_12", 128'(bus.done), 128'd1);
    chk("appC1_ct", bus.ciphertext, CT_C);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (3) @(posedge CLK);

    // Reset in the middle of a run
    @(negedge CLK);
    tb_key = KEY_B; bus.plaintext = PT_B; bus.start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_zero_outputs("midrun_reset");
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Restart with App. B after the abort
    @(negedge CLK);
    tb_key = KEY_B; bus.plaintext = PT_B; bus.start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    wait_done(20);
    chk("restart_appB_ct", bus.ciphertext, CT_B);

    // Back-to-back random blocks, each start issued in the previous done cycle
    for (int b = 0; b < 3; b++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      tb_key = k; bus.plaintext = p; bus.start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      bus.start = 1'b0;
      wait_done(20);
      chk("rand_ct", bus.ciphertext, aes_ref(k, p));
    end

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
